// File: rtl/reg_file_pbank.sv
// General-purpose register file: 3 async reads, 1 sync write, I2C command handshake and double-buffered PWM bank.
// Optional RF_BYPASS_EN: same-cycle write-to-read forwarding for accepted writes.
module reg_file_pbank #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned PWM_CH      = 8,
  parameter int unsigned PWM_BASE    = 8,
  parameter int unsigned I2C_CMD_REG = 6,
  parameter int unsigned I2C_DAT_REG = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  input  logic [ADDR_W-1:0]        rd_addr_c,
  output logic [DATA_W-1:0]        rd_a,
  output logic [DATA_W-1:0]        rd_b,
  output logic [DATA_W-1:0]        rd_c,
  output logic                     i2c_go,
  output logic                     i2c_busy,
  input  logic                     i2c_done,
  input  logic [1:0]               i2c_sts,
  input  logic [7:0]               i2c_rx_data,
  output logic [8:0]               i2c_addr,
  output logic [7:0]               i2c_slave_addr,
  output logic [7:0]               i2c_tx_data,
  input  logic                     pwm_frame,
  output logic                     pwm_pending,
  output logic [PWM_CH*DATA_W-1:0] pwm_flat
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CMD_A = ADDR_W'(I2C_CMD_REG);
  localparam logic [ADDR_W-1:0] DAT_A = ADDR_W'(I2C_DAT_REG);
  localparam logic [ADDR_W:0]   PWM_LO = (ADDR_W+1)'(PWM_BASE);
  localparam logic [ADDR_W:0]   PWM_HI = (ADDR_W+1)'(PWM_BASE + PWM_CH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [DATA_W-1:0] regs   [NUM_REGS];
  logic [DATA_W-1:0] active [PWM_CH];
  logic [1:0]        state;

  logic i2c_target, wr_reject, wr_accept, wr_pwm, go_req, done_cap;

  always_comb begin
    i2c_target = (wr_addr == CMD_A) || (wr_addr == DAT_A);
    wr_reject  = write_en && i2c_target && (state != ST_IDLE);
    wr_accept  = write_en && (wr_addr != '0) && !wr_reject;
    wr_pwm     = wr_accept && ({1'b0, wr_addr} >= PWM_LO) && ({1'b0, wr_addr} < PWM_HI);
    go_req     = wr_accept && (wr_addr == CMD_A) && wr_data[15];
    done_cap   = (state == ST_WAIT) && i2c_done;
  end

  // A rejected CMD/DAT write only raises ERR; it never masks a same-cycle done capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (wr_accept) regs[wr_addr] <= wr_data;
      if (wr_reject) regs[CMD_A][11] <= 1'b1;
      if (done_cap) begin
        regs[CMD_A][10:9] <= i2c_sts;
        regs[CMD_A][15]   <= 1'b0;
        regs[DAT_A][15:8] <= i2c_rx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (go_req) state <= ST_ISSUE;
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT:  if (i2c_done) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Commit copies the pre-edge shadow, so a coinciding write stays pending for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PWM_CH; i++) active[i] <= '0;
      pwm_pending <= 1'b0;
    end else begin
      if (pwm_frame) begin
        for (int unsigned i = 0; i < PWM_CH; i++) active[i] <= regs[ADDR_W'(PWM_BASE + i)];
      end
      if (wr_pwm) pwm_pending <= 1'b1;
      else if (pwm_frame) pwm_pending <= 1'b0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < PWM_CH; i++) pwm_flat[i*DATA_W +: DATA_W] = active[i];
  end

  assign i2c_go         = (state == ST_ISSUE);
  assign i2c_busy       = (state != ST_IDLE);
  assign i2c_addr       = regs[CMD_A][8:0];
  assign i2c_slave_addr = regs[DAT_A][7:0];
  assign i2c_tx_data    = regs[DAT_A][15:8];

  always_comb begin
    rd_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    rd_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
    rd_c = (rd_addr_c == '0) ? '0 : regs[rd_addr_c];
`ifdef RF_BYPASS_EN
    if (wr_accept && (wr_addr == rd_addr_a)) rd_a = wr_data;
    if (wr_accept && (wr_addr == rd_addr_b)) rd_b = wr_data;
    if (wr_accept && (wr_addr == rd_addr_c)) rd_c = wr_data;
`endif
  end

endmodule

// File: tb/tb_reg_file_pbank.sv
// Directed self-checking bench for reg_file_pbank (default parameters): read/write table plus I2C and PWM sequences.
module tb_reg_file_pbank;

  logic         clk = 1'b0;
  logic         rst, write_en, i2c_done, pwm_frame;
  logic [3:0]   wr_addr, rd_addr_a, rd_addr_b, rd_addr_c;
  logic [15:0]  wr_data, rd_a, rd_b, rd_c;
  logic         i2c_go, i2c_busy, pwm_pending;
  logic [1:0]   i2c_sts;
  logic [7:0]   i2c_rx_data, i2c_slave_addr, i2c_tx_data;
  logic [8:0]   i2c_addr;
  logic [127:0] pwm_flat;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  reg_file_pbank #(
    .DATA_W(16), .ADDR_W(4), .PWM_CH(8), .PWM_BASE(8), .I2C_CMD_REG(6), .I2C_DAT_REG(7)
  ) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
    .i2c_go(i2c_go), .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_sts(i2c_sts),
    .i2c_rx_data(i2c_rx_data), .i2c_addr(i2c_addr), .i2c_slave_addr(i2c_slave_addr),
    .i2c_tx_data(i2c_tx_data), .pwm_frame(pwm_frame), .pwm_pending(pwm_pending),
    .pwm_flat(pwm_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra, rb, rc;
    logic [15:0] ea, eb, ec;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    write_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    write_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
    rd_addr_b = a;
    #1;
    check(name, {16'h0, rd_b}, {16'h0, exp});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; rd_addr_c = '0;
    i2c_done = 1'b0; i2c_sts = '0; i2c_rx_data = '0; pwm_frame = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a); rd_addr_b = 4'(a); rd_addr_c = 4'(a);
      #1;
      check("reset_rd", {rd_a, rd_b, rd_c[15:0]} == '0 ? 32'd0 : 32'd1, 32'd0);
    end
    check("reset_go_busy", {30'h0, i2c_go, i2c_busy}, 32'h0);
    check("reset_pend", {31'h0, pwm_pending}, 32'h0);
    check("reset_flat", {31'h0, pwm_flat != '0}, 32'h0);

    // Reads are sampled before the write edge, so they show pre-write content.
    vecs[0] = '{1'b0, 4'd0,  16'h0000, 4'd0, 4'd1, 4'd15, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 4'd0,  16'hBEEF, 4'd0, 4'd2, 4'd3,  16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 4'd3,  16'h1234, 4'd0, 4'd0, 4'd0,  16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{1'b0, 4'd0,  16'h0000, 4'd3, 4'd3, 4'd3,  16'h1234, 16'h1234, 16'h1234};
    vecs[4] = '{1'b1, 4'd15, 16'hCAFE, 4'd3, 4'd0, 4'd14, 16'h1234, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd3, 4'd0, 16'hCAFE, 16'h1234, 16'h0000};
    vecs[6] = '{1'b1, 4'd1,  16'hFFFF, 4'd15, 4'd2, 4'd0, 16'hCAFE, 16'h0000, 16'h0000};
    vecs[7] = '{1'b0, 4'd0,  16'h0000, 4'd1, 4'd15, 4'd3, 16'hFFFF, 16'hCAFE, 16'h1234};
    for (int i = 0; i < 8; i++) begin
      write_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb; rd_addr_c = vecs[i].rc;
      #1;
      check($sformatf("vec%0d_a", i), {16'h0, rd_a}, {16'h0, vecs[i].ea});
      check($sformatf("vec%0d_b", i), {16'h0, rd_b}, {16'h0, vecs[i].eb});
      check($sformatf("vec%0d_c", i), {16'h0, rd_c}, {16'h0, vecs[i].ec});
      step();
    end
    write_en = 1'b0;
    rd_chk("addr0_after_beef", 4'd0, 16'h0000);

    // I2C transaction, clean completion
    wr(4'd7, 16'hA550);
    wr(4'd6, 16'h8012);
    check("go_pulse", {30'h0, i2c_go, i2c_busy}, 32'h3);
    check("i2c_addr", {23'h0, i2c_addr}, 32'h012);
    check("i2c_slave", {24'h0, i2c_slave_addr}, 32'h50);
    check("i2c_tx", {24'h0, i2c_tx_data}, 32'hA5);
    step();
    check("go_width", {30'h0, i2c_go, i2c_busy}, 32'h1);
    i2c_done = 1'b1; i2c_sts = 2'b01; i2c_rx_data = 8'h3C;
    step();
    i2c_done = 1'b0;
    check("busy_after_done", {31'h0, i2c_busy}, 32'h0);
    rd_chk("cmd_after_done", 4'd6, 16'h0212);
    rd_chk("dat_after_done", 4'd7, 16'h3C50);

    // Second transaction: rejected writes set ERR, one coincides with done
    wr(4'd6, 16'h8034);
    step();
    wr(4'd7, 16'hFFFF);
    rd_chk("dat_rejected", 4'd7, 16'h3C50);
    rd_chk("cmd_err_set", 4'd6, 16'h8834);
    write_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h1234;
    i2c_done = 1'b1; i2c_sts = 2'b10; i2c_rx_data = 8'h99;
    step();
    write_en = 1'b0; i2c_done = 1'b0;
    rd_chk("cmd_rej_plus_done", 4'd6, 16'h0C34);
    rd_chk("dat_rej_plus_done", 4'd7, 16'h9950);
    check("busy_idle2", {31'h0, i2c_busy}, 32'h0);
    i2c_done = 1'b1; i2c_sts = 2'b11; i2c_rx_data = 8'h77;
    step();
    i2c_done = 1'b0;
    rd_chk("idle_done_ignored", 4'd6, 16'h0C34);
    rd_chk("idle_done_dat", 4'd7, 16'h9950);
    wr(4'd6, 16'h0000);
    rd_chk("err_cleared", 4'd6, 16'h0000);
    check("no_go_on_clear", {30'h0, i2c_go, i2c_busy}, 32'h0);

    // Reset mid-transaction, late done ignored
    wr(4'd6, 16'h8001);
    check("go_before_rst", {31'h0, i2c_go}, 32'h1);
    do_reset();
    check("rst_mid_go_busy", {30'h0, i2c_go, i2c_busy}, 32'h0);
    i2c_done = 1'b1; i2c_sts = 2'b11; i2c_rx_data = 8'h55;
    step();
    i2c_done = 1'b0;
    check("late_done_busy", {31'h0, i2c_busy}, 32'h0);
    rd_chk("late_done_cmd", 4'd6, 16'h0000);
    rd_chk("late_done_dat", 4'd7, 16'h0000);

    // PWM double buffering (ch2 = addr 10, ch7 = addr 15)
    wr(4'd10, 16'h0400);
    check("pend_after_wr", {31'h0, pwm_pending}, 32'h1);
    check("ch2_not_yet", {16'h0, pwm_flat[32 +: 16]}, 32'h0000);
    rd_chk("shadow_ch2", 4'd10, 16'h0400);
    pwm_frame = 1'b1; step(); pwm_frame = 1'b0;
    check("ch2_commit", {16'h0, pwm_flat[32 +: 16]}, 32'h0400);
    check("pend_cleared", {31'h0, pwm_pending}, 32'h0);
    write_en = 1'b1; wr_addr = 4'd10; wr_data = 16'h0800; pwm_frame = 1'b1;
    step();
    write_en = 1'b0; pwm_frame = 1'b0;
    check("ch2_wr_frame", {16'h0, pwm_flat[32 +: 16]}, 32'h0400);
    check("pend_wr_frame", {31'h0, pwm_pending}, 32'h1);
    wr(4'd15, 16'h7777);
    pwm_frame = 1'b1; step(); pwm_frame = 1'b0;
    check("ch2_second", {16'h0, pwm_flat[32 +: 16]}, 32'h0800);
    check("ch7_commit", {16'h0, pwm_flat[112 +: 16]}, 32'h7777);
    check("ch0_untouched", {16'h0, pwm_flat[0 +: 16]}, 32'h0000);
    check("pend_final", {31'h0, pwm_pending}, 32'h0);
    wr(4'd5, 16'h1111);
    check("non_pwm_no_pend", {31'h0, pwm_pending}, 32'h0);

    // Same-cycle read of a register being written
    wr(4'd5, 16'h0011);
    write_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h00AA; rd_addr_a = 4'd5;
    #1;
`ifdef RF_BYPASS_EN
    check("same_cycle_rd", {16'h0, rd_a}, 32'h00AA);
`else
    check("same_cycle_rd", {16'h0, rd_a}, 32'h0011);
`endif
    step();
    write_en = 1'b0;
    check("next_cycle_rd", {16'h0, rd_a}, 32'h00AA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
